// File: rtl/s011hd1p_x32y2d128.sv
// Single-port synchronous RAM, DEPTH x WIDTH, registered read port.
// The array has no reset, so its contents survive reset. Q clears on reset.
module s011hd1p_x32y2d128 #(
    parameter int DEPTH  = 64,
    parameter int WIDTH  = 128,
    parameter int ADDR_W = 6
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              CEN,
    input  logic              WEN,
    input  logic [ADDR_W-1:0] A,
    input  logic [WIDTH-1:0]  D,
    output logic [WIDTH-1:0]  Q
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] q_d, q_q;
    logic             wr_en, rd_en;

    always_comb begin
        wr_en = RSTN & ~CEN & ~WEN;
        rd_en = RSTN & ~CEN & WEN;
        q_d   = q_q;
        if (!RSTN) begin
            q_d = '0;
        end else if (rd_en) begin
            q_d = mem_q[A];
        end
    end

    // Reset overrides any access, so a write is gated by RSTN as well.
    always_ff @(posedge CLK) begin
        q_q <= q_d;
        if (wr_en) begin
            mem_q[A] <= D;
        end
    end

    assign Q = q_q;

endmodule

// File: tb/tb_s011hd1p_x32y2d128.sv
// Self-checking bench for s011hd1p_x32y2d128.
// Directed scenarios plus random traffic against an array-based model.
module tb_s011hd1p_x32y2d128;

    localparam int DEPTH  = 64;
    localparam int WIDTH  = 128;
    localparam int ADDR_W = 6;

    logic              CLK = 1'b0;
    logic              RSTN;
    logic              CEN;
    logic              WEN;
    logic [ADDR_W-1:0] A;
    logic [WIDTH-1:0]  D;
    logic [WIDTH-1:0]  Q;

    int vectors     = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] ref_mem [DEPTH];
    bit               ref_vld [DEPTH];
    logic [WIDTH-1:0] ref_q;

    s011hd1p_x32y2d128 #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .CLK (CLK),
        .RSTN(RSTN),
        .CEN (CEN),
        .WEN (WEN),
        .A   (A),
        .D   (D),
        .Q   (Q)
    );

    always #5 CLK = ~CLK;

    function automatic logic [WIDTH-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock cycle with the given inputs; the model then applies
    // the RAM rules and the caller compares Q just after the edge.
    task automatic apply(input logic rstn, input logic cen,
                         input logic wen, input logic [ADDR_W-1:0] a,
                         input logic [WIDTH-1:0] d);
        RSTN = rstn;
        CEN  = cen;
        WEN  = wen;
        A    = a;
        D    = d;
        @(posedge CLK);
        #1;
        if (!rstn) begin
            ref_q = '0;
        end else if (!cen) begin
            if (!wen) begin
                ref_mem[a] = d;
                ref_vld[a] = 1'b1;
            end else begin
                ref_q = ref_mem[a];
            end
        end
    endtask

    task automatic test_reset();
        logic [WIDTH-1:0] v;
        apply(0, 1, 1, 0, '0);
        vectors++;
        if (Q !== '0) begin
            miscompares++;
            $display("FAIL reset_init: Q=%h expected 0", Q);
        end
        v = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
        apply(1, 0, 0, 2, v);
        apply(1, 0, 1, 2, '0);
        vectors++;
        if (Q !== v) begin
            miscompares++;
            $display("FAIL reset_pre: Q=%h expected %h", Q, v);
        end
        for (int i = 0; i < 2; i++) begin
            apply(0, 0, 1, 2, '0);
            vectors++;
            if (Q !== '0) begin
                miscompares++;
                $display("FAIL reset_cyc%0d: Q=%h expected 0", i, Q);
            end
        end
    endtask

    task automatic test_write_read();
        logic [WIDTH-1:0] v;
        v = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        apply(1, 0, 0, 5, v);
        vectors++;
        if (Q !== '0) begin
            miscompares++;
            $display("FAIL wr_no_thru: Q=%h expected 0", Q);
        end
        apply(1, 0, 1, 5, '0);
        vectors++;
        if (Q !== v) begin
            miscompares++;
            $display("FAIL rd5: Q=%h expected %h", Q, v);
        end
    endtask

    task automatic test_hold_idle();
        logic [WIDTH-1:0] v;
        v = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        for (int i = 0; i < 3; i++) begin
            apply(1, 1, 0, 5, '0);
            vectors++;
            if (Q !== v) begin
                miscompares++;
                $display("FAIL idle%0d: Q=%h expected %h", i, Q, v);
            end
        end
        apply(1, 1, 1, 9, rand_word());
        apply(1, 0, 1, 5, '0);
        vectors++;
        if (Q !== v) begin
            miscompares++;
            $display("FAIL idle_reread: Q=%h expected %h", Q, v);
        end
    endtask

    task automatic test_write_no_disturb();
        logic [WIDTH-1:0] v0;
        v0 = 128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_0F0F;
        apply(1, 0, 0, 0, v0);
        apply(1, 0, 1, 0, '0);
        vectors++;
        if (Q !== v0) begin
            miscompares++;
            $display("FAIL rd0: Q=%h expected %h", Q, v0);
        end
        apply(1, 0, 0, 1, '1);
        vectors++;
        if (Q !== v0) begin
            miscompares++;
            $display("FAIL wr1_hold: Q=%h expected %h", Q, v0);
        end
        apply(1, 0, 1, 1, '0);
        vectors++;
        if (Q !== {WIDTH{1'b1}}) begin
            miscompares++;
            $display("FAIL rd1_ones: Q=%h expected all-ones", Q);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0]      w;
        logic [WIDTH-1:0] pat;
        int               bad;
        bad = 0;
        for (int a = 0; a < DEPTH; a++) begin
            w = 32'(a);
            apply(1, 0, 0, ADDR_W'(a), {4{w}});
        end
        for (int a = DEPTH - 1; a >= 0; a--) begin
            w   = 32'(a);
            pat = {4{w}};
            apply(1, 0, 1, ADDR_W'(a), '0);
            vectors++;
            if (Q !== pat) begin
                miscompares++;
                bad++;
                if (bad < 5)
                    $display("FAIL b2b_rd%0d: Q=%h expected %h", a, Q, pat);
            end
        end
    endtask

    task automatic test_reset_vs_write();
        logic [WIDTH-1:0] x1, x2;
        x1 = rand_word();
        x2 = ~x1;
        apply(1, 0, 0, 7, x1);
        apply(0, 0, 0, 7, x2);
        vectors++;
        if (Q !== '0) begin
            miscompares++;
            $display("FAIL rst_wr_q: Q=%h expected 0", Q);
        end
        apply(1, 0, 1, 7, '0);
        vectors++;
        if (Q !== x1) begin
            miscompares++;
            $display("FAIL rst_wr_mem: Q=%h expected %h", Q, x1);
        end
    endtask

    task automatic test_random();
        logic              rstn, cen, wen;
        logic [ADDR_W-1:0] a;
        int                bad;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            rstn = ($urandom_range(0, 24) != 0);
            cen  = ($urandom_range(0, 3) == 0);
            wen  = $urandom_range(0, 1) != 0;
            a    = ADDR_W'($urandom_range(0, DEPTH - 1));
            if (rstn && !cen && wen && !ref_vld[a]) wen = 1'b0;
            apply(rstn, cen, wen, a, rand_word());
            vectors++;
            if (Q !== ref_q) begin
                miscompares++;
                bad++;
                if (bad < 5)
                    $display("FAIL rand%0d: Q=%h expected %h", i, Q, ref_q);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = '0;
            ref_vld[i] = 1'b0;
        end
        ref_q = '0;
        RSTN  = 1'b0;
        CEN   = 1'b1;
        WEN   = 1'b1;
        A     = '0;
        D     = '0;
        test_reset();
        test_write_read();
        test_hold_idle();
        test_write_no_disturb();
        test_back_to_back();
        test_reset_vs_write();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/s011hd1p_x32y2d128.md
S011HD1P_X32Y2D128 -- requirements
Module: s011hd1p_x32y2d128

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning number of words.
REQ-002 SHALL have parameter WIDTH, default 128, meaning data bits per word.
REQ-003 SHALL have parameter ADDR_W, default 6, meaning address bits, with DEPTH = 2^ADDR_W.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port RSTN, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port CEN, input, 1 bit: chip enable, active-low.
REQ-007 SHALL have port WEN, input, 1 bit: write enable, active-low, qualified by CEN.
REQ-008 SHALL have port A, input, ADDR_W bits: word address.
REQ-009 SHALL have port D, input, WIDTH bits: write data.
REQ-010 SHALL have port Q, output, WIDTH bits: registered read data.

Function
REQ-011 SHALL implement a single-port synchronous RAM of DEPTH x WIDTH bits, allowing one access per cycle.
REQ-012 SHALL perform a write when RSTN=1, CEN=0 and WEN=0 at a rising edge: mem[A] <= D, full word, no byte mask.
REQ-013 SHALL perform a read when RSTN=1, CEN=0 and WEN=1 at a rising edge: Q <= mem[A], 1-cycle latency, so Q is valid the cycle after the request.
REQ-014 SHALL leave Q unchanged on a write cycle, with no write-through to Q.
REQ-015 SHALL hold Q and memory unchanged when CEN=1, regardless of WEN, A and D.
REQ-016 SHALL hold Q stable indefinitely between read cycles, so the last read data stays readable until the next read or reset.
REQ-017 SHALL make a read of address X in the cycle after a write to X return the newly written data.
REQ-018 SHALL accept back-to-back reads and writes to any addresses every cycle, with no stall and no ready/valid handshake.
REQ-019 SHALL use the full A range 0..DEPTH-1 with no wrap or aliasing; every A value maps to a distinct word.
REQ-020 SHALL produce Q as a pure register output, with no combinational path from A, D, CEN or WEN to Q.
REQ-021 SHALL give X/undefined inputs on a non-enabled cycle (CEN=1) no effect on state.

Reset
REQ-022 SHALL clear Q to all zeros at a rising edge with RSTN=0.
REQ-023 SHALL let reset override any access, so a cycle with RSTN=0 and CEN=0, WEN=0 performs no write and leaves memory unchanged.
REQ-024 SHALL NOT initialise or clear memory contents on reset; contents survive reset, and power-up contents are undefined and must not be relied on.
REQ-025 SHALL allow reset mid-operation: the first cycle after RSTN returns to 1 accepts a new access normally.

Verification
REQ-026 Reset: hold RSTN=0 for 2 cycles with Q previously nonzero -> Q = 0 after the first reset edge.
REQ-027 Write/read: write A=5, D=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210; next cycle read A=5 -> Q equals that value one cycle after the read edge.
REQ-028 Hold and idle: after reading A=5, drive CEN=1 with WEN=0, A=5, D=0 for 3 cycles -> Q unchanged, and a later read of A=5 returns the original value.
REQ-029 Write does not disturb Q: read A=0 (value V0), then write A=1, D=all-ones -> Q stays V0; then read A=1 -> Q = all-ones.
REQ-030 Address range and back-to-back: write A=0..63 with D = {4{A replicated into 32 bits}} on consecutive cycles, then read A=63 down to 0 consecutively -> each Q matches, with 1-cycle latency.
REQ-031 Reset versus write: write A=7, D=X1; then assert RSTN=0 with CEN=0, WEN=0, A=7, D=X2; release and read A=7 -> Q = X1.
